// File: rtl/p_pkg.sv
// Shared types and defaults for the pin serializer.
// PARITY exists only when P_SERIALIZER_PARITY_EN is defined.
package p_pkg;

   localparam int P_DEFAULT_DATA_WIDTH = 8;
   localparam int P_DEFAULT_FIFO_DEPTH = 4;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
`ifdef P_SERIALIZER_PARITY_EN
      PARITY = 2'd2,
`endif
      GAP    = 2'd3
   } p_ser_state_e;

endpackage

// File: rtl/p_sync_fifo.sv
// Small synchronous FIFO: registered count, power-of-two depth, wrapping pointers.
// Read data is the word at the read pointer; it is valid whenever empty is low.
module p_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic                       pop,
   input  logic [WIDTH-1:0]           wdata,
   output logic [WIDTH-1:0]           rdata,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     level
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [LW-1:0]    count;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == LW'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rdata   = mem[rd_ptr];
   assign level   = count;

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + LW'(1);
            2'b01:   count <= count - LW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/p_pin_serializer.sv
// Parallel-to-pin serializer: FIFO-buffered words sent LSB-first on p_frame/p_sdata
// with a one-cycle gap; define P_SERIALIZER_PARITY_EN to append an even-parity bit.
module p_pin_serializer
   import p_pkg::*;
#(
   parameter int DATA_WIDTH = P_DEFAULT_DATA_WIDTH,
   parameter int FIFO_DEPTH = P_DEFAULT_FIFO_DEPTH
) (
   input  logic                          pclk,
   input  logic                          preset,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [DATA_WIDTH-1:0]         in_data,
   output logic                          p_frame,
   output logic                          p_sdata,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic                          busy,
   output logic [1:0]                    state_dbg
);

   localparam int CW = $clog2(DATA_WIDTH);

   p_ser_state_e          state;
   logic [DATA_WIDTH-1:0] shreg;
   logic [CW-1:0]         bit_cnt;
   logic [DATA_WIDTH-1:0] fifo_rdata;
   logic                  fifo_full;
   logic                  fifo_empty;
   logic                  pop;
`ifdef P_SERIALIZER_PARITY_EN
   logic                  par_bit;
`endif

   // Handshake: a word transfers on any rising edge where in_valid && in_ready;
   // in_ready is !full from the count register, so it never depends on in_valid.
   p_sync_fifo #(
      .WIDTH (DATA_WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (pclk),
      .rst   (preset),
      .push  (in_valid),
      .pop   (pop),
      .wdata (in_data),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty),
      .level (fifo_level)
   );

   assign in_ready  = !fifo_full;
   assign pop       = ((state == IDLE) || (state == GAP)) && !fifo_empty;
   assign busy      = (state != IDLE) || (fifo_level != '0);
   assign state_dbg = state;

   // Pin outputs are registered: bit 0 is presented on the load edge, the
   // remaining bits are taken from the pre-shifted register.
   always_ff @(posedge pclk) begin
      if (preset) begin
         state   <= IDLE;
         shreg   <= '0;
         bit_cnt <= '0;
         p_frame <= 1'b0;
         p_sdata <= 1'b0;
`ifdef P_SERIALIZER_PARITY_EN
         par_bit <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE, GAP: begin
               if (!fifo_empty) begin
                  state   <= SHIFT;
                  shreg   <= fifo_rdata >> 1;
                  bit_cnt <= '0;
                  p_frame <= 1'b1;
                  p_sdata <= fifo_rdata[0];
`ifdef P_SERIALIZER_PARITY_EN
                  par_bit <= ^fifo_rdata;
`endif
               end else begin
                  state   <= IDLE;
                  p_frame <= 1'b0;
                  p_sdata <= 1'b0;
               end
            end
            SHIFT: begin
               if (bit_cnt == CW'(DATA_WIDTH - 1)) begin
`ifdef P_SERIALIZER_PARITY_EN
                  state   <= PARITY;
                  p_sdata <= par_bit;
`else
                  state   <= GAP;
                  p_frame <= 1'b0;
                  p_sdata <= 1'b0;
`endif
               end else begin
                  bit_cnt <= bit_cnt + CW'(1);
                  p_sdata <= shreg[0];
                  shreg   <= shreg >> 1;
               end
            end
`ifdef P_SERIALIZER_PARITY_EN
            PARITY: begin
               state   <= GAP;
               p_frame <= 1'b0;
               p_sdata <= 1'b0;
            end
`endif
            default: begin
               state   <= IDLE;
               p_frame <= 1'b0;
               p_sdata <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_p_pin_serializer.sv
// Bench for p_pin_serializer: directed pushes feed an expected-frame queue,
// a negedge monitor reassembles frames from the pins and checks them in order.
module tb_p_pin_serializer;
   import p_pkg::*;

   localparam int DW = 8;
   localparam int DEPTH = 4;
   localparam int LW = $clog2(DEPTH) + 1;
   localparam int FW = DW + 1;
`ifdef P_SERIALIZER_PARITY_EN
   localparam int FLEN = DW + 1;
`else
   localparam int FLEN = DW;
`endif

   logic          pclk;
   logic          preset;
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] in_data;
   logic          p_frame;
   logic          p_sdata;
   logic [LW-1:0] fifo_level;
   logic          busy;
   logic [1:0]    state_dbg;

   logic [FW-1:0] exp_q[$];
   int            total = 0;
   int            bad = 0;
   int            frames = 0;

   p_pin_serializer #(
      .DATA_WIDTH (DW),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .pclk       (pclk),
      .preset     (preset),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .p_frame    (p_frame),
      .p_sdata    (p_sdata),
      .fifo_level (fifo_level),
      .busy       (busy),
      .state_dbg  (state_dbg)
   );

   // clock / reset
   initial pclk = 1'b0;
   always #5 pclk = ~pclk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
      end
   endtask

   // driver: holds the word until accepted, records the expected frame on acceptance
   task automatic push(input logic [DW-1:0] d, input logic par);
      int guard;
      guard = 0;
      in_valid = 1'b1;
      in_data  = d;
      while (!in_ready && guard < 200) begin
         @(negedge pclk);
         guard++;
      end
      if (!in_ready) begin
         check("push_timeout", 32'(in_ready), 32'd1);
         in_valid = 1'b0;
      end else begin
         @(posedge pclk);
`ifdef P_SERIALIZER_PARITY_EN
         exp_q.push_back({par, d});
`else
         exp_q.push_back({1'b0, d});
`endif
         #1 in_valid = 1'b0;
      end
   endtask

   task automatic wait_idle(input string name);
      int guard;
      guard = 0;
      @(negedge pclk);
      while ((busy || exp_q.size() != 0) && guard < 2000) begin
         @(negedge pclk);
         guard++;
      end
      check({name, "_drain"}, 32'(exp_q.size()), 32'd0);
      check({name, "_idle"}, 32'(busy), 32'd0);
   endtask

   // scoreboard monitor
   initial begin
      int            nbits;
      int            low_run;
      logic          pending;
      logic [FW-1:0] got;
      logic [FW-1:0] e;
      nbits = 0; low_run = 0; pending = 1'b0; got = '0;
      forever begin
         @(negedge pclk);
         if (preset) begin
            nbits = 0; got = '0; pending = 1'b0; low_run = 0;
         end else if (p_frame) begin
            if (nbits == 0 && pending) check("gap_len", 32'(low_run), 32'd1);
            pending = 1'b0;
            if (nbits < FW) got[nbits] = p_sdata;
            nbits++;
         end else begin
            if (nbits > 0) begin
               check("frame_len", 32'(nbits), 32'(FLEN));
               check("gap_sdata", 32'(p_sdata), 32'd0);
               if (exp_q.size() == 0) begin
                  total++; bad++;
                  $display("FAIL unexpected_frame: got %0h want none", got);
               end else begin
                  e = exp_q.pop_front();
                  check("frame_data", 32'(got), 32'(e));
               end
               frames++;
               nbits = 0; got = '0; low_run = 0;
               pending = (exp_q.size() != 0);
            end
            low_run++;
         end
      end
   end

   // stimulus
   initial begin
      logic [7:0] seq_a5;
      int         frames_before;
      logic       saw;
      int         guard;

      preset = 1'b1; in_valid = 1'b0; in_data = '0;
      repeat (3) @(posedge pclk);
      #1 preset = 1'b0;
      @(negedge pclk);
      check("rst_frame", 32'(p_frame), 32'd0);
      check("rst_sdata", 32'(p_sdata), 32'd0);
      check("rst_ready", 32'(in_ready), 32'd1);
      check("rst_level", 32'(fifo_level), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_state", 32'(state_dbg), 32'(IDLE));

      // in_valid low: nothing is taken
      repeat (6) begin
         in_data = 8'($urandom_range(0, 255));
         @(negedge pclk);
         check("novalid_level", 32'(fifo_level), 32'd0);
         check("novalid_frame", 32'(p_frame), 32'd0);
      end

      // single word 0xA5, pin-level cycle check
      seq_a5 = 8'b1010_0101;
      @(posedge pclk); #1;
      push(8'hA5, 1'b0);
      @(negedge pclk);
      check("a5_level", 32'(fifo_level), 32'd1);
      check("a5_prefr", 32'(p_frame), 32'd0);
      for (int i = 0; i < DW; i++) begin
         @(negedge pclk);
         check("a5_frame", 32'(p_frame), 32'd1);
         check("a5_bit", 32'(p_sdata), 32'(seq_a5[i]));
      end
`ifdef P_SERIALIZER_PARITY_EN
      @(negedge pclk);
      check("a5_par", 32'(p_sdata), 32'd0);
`endif
      @(negedge pclk);
      check("a5_gap_frame", 32'(p_frame), 32'd0);
      check("a5_gap_busy", 32'(busy), 32'd1);
      @(negedge pclk);
      check("a5_after_busy", 32'(busy), 32'd0);
      check("a5_after_frame", 32'(p_frame), 32'd0);

      // five back-to-back words fill the FIFO
      @(posedge pclk); #1;
      push(8'h01, 1'b1);
      push(8'h02, 1'b1);
      push(8'h03, 1'b0);
      push(8'h04, 1'b1);
      push(8'h05, 1'b0);
      @(negedge pclk);
      check("full_level", 32'(fifo_level), 32'd4);
      check("full_ready", 32'(in_ready), 32'd0);
      wait_idle("burst");

      // parity vectors (plain frames without the parity build)
      @(posedge pclk); #1;
      push(8'h07, 1'b1);
      push(8'h03, 1'b0);
      wait_idle("parity");

      // push coinciding with the pop at level 2, then wrap through 10 words
      @(posedge pclk); #1;
      push(8'h30, 1'b0);
      push(8'h31, 1'b1);
      push(8'h32, 1'b1);
      guard = 0;
      @(negedge pclk);
      while (p_frame && guard < 50) begin
         @(negedge pclk);
         guard++;
      end
      check("gap_reached", 32'(p_frame), 32'd0);
      check("pre_pop_level", 32'(fifo_level), 32'd2);
      push(8'h33, 1'b0);
      @(negedge pclk);
      check("pushpop_level", 32'(fifo_level), 32'd2);
      push(8'h34, 1'b1);
      push(8'h35, 1'b0);
      push(8'h36, 1'b0);
      push(8'h37, 1'b1);
      push(8'h38, 1'b1);
      push(8'h39, 1'b0);
      wait_idle("wrap");

      // reset during bit 3 with two words queued
      @(posedge pclk); #1;
      push(8'h11, 1'b0);
      push(8'h22, 1'b0);
      push(8'h33, 1'b0);
      @(posedge pclk);
      @(posedge pclk);
      #1;
      check("abort_level", 32'(fifo_level), 32'd2);
      preset = 1'b1;
      @(posedge pclk); #1 preset = 1'b0;
      @(negedge pclk);
      check("abort_frame", 32'(p_frame), 32'd0);
      check("abort_level0", 32'(fifo_level), 32'd0);
      check("abort_ready", 32'(in_ready), 32'd1);
      check("abort_busy", 32'(busy), 32'd0);
      exp_q.delete();
      frames_before = frames;
      saw = 1'b0;
      repeat (30) begin
         @(negedge pclk);
         if (p_frame) saw = 1'b1;
      end
      check("abort_no_frame", 32'(saw), 32'd0);
      check("abort_frames", 32'(frames), 32'(frames_before));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
